// File: rtl/nms_core.sv
// Non-maximum suppression core: 2-stage pipeline over a 3x3 magnitude window with line/frame tracking.
// Optional double-threshold classification of kept pixels enabled by macro NMS_DOUBLE_THRESH_EN.
module nms_core #(
  parameter int unsigned DATAWID         = 8,
  parameter int unsigned WINDOW_DATA_WID = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic [WINDOW_DATA_WID-1:0] window_data,
  input  logic [1:0]                 dir,
  input  logic [10:0]                IW,
  input  logic [10:0]                IH,
`ifdef NMS_DOUBLE_THRESH_EN
  input  logic [DATAWID-1:0]         th_low,
  input  logic [DATAWID-1:0]         th_high,
`endif
  output logic [DATAWID-1:0]         dout,
  output logic                       dout_valid,
  output logic                       dout_eol,
  output logic                       dout_eof
);

  localparam int unsigned CNT_W = 11;

`ifdef NMS_DOUBLE_THRESH_EN
  localparam logic [DATAWID-1:0] STRONG_VAL = {DATAWID{1'b1}};
  localparam logic [DATAWID-1:0] WEAK_VAL   = DATAWID'(1) << (DATAWID - 1);
`endif

  logic [DATAWID-1:0] c_c;
  logic [DATAWID-1:0] n0_c;
  logic [DATAWID-1:0] n1_c;

  logic               s1_valid;
  logic [DATAWID-1:0] s1_c;
  logic [DATAWID-1:0] s1_n0;
  logic [DATAWID-1:0] s1_n1;

  logic [CNT_W-1:0]   col;
  logic [CNT_W-1:0]   row;

  logic               keep_c;
  logic [DATAWID-1:0] pix_c;
  logic               last_col_c;
  logic               last_row_c;

  // Pick the two neighbours lying along the gradient direction
  always_comb begin
    c_c  = window_data[4*DATAWID +: DATAWID];
    n0_c = window_data[5*DATAWID +: DATAWID];
    n1_c = window_data[3*DATAWID +: DATAWID];
    case (dir)
      2'd1: begin
        n0_c = window_data[8*DATAWID +: DATAWID];
        n1_c = window_data[0 +: DATAWID];
      end
      2'd2: begin
        n0_c = window_data[7*DATAWID +: DATAWID];
        n1_c = window_data[1*DATAWID +: DATAWID];
      end
      2'd3: begin
        n0_c = window_data[6*DATAWID +: DATAWID];
        n1_c = window_data[2*DATAWID +: DATAWID];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_n0    <= '0;
      s1_n1    <= '0;
    end else begin
      s1_valid <= din_valid;
      s1_c     <= c_c;
      s1_n0    <= n0_c;
      s1_n1    <= n1_c;
    end
  end

  // Ties keep the centre so flat ridges are not erased entirely
  always_comb begin
    keep_c     = (s1_c >= s1_n0) && (s1_c >= s1_n1);
    pix_c      = '0;
    last_col_c = (col == (IW - CNT_W'(1)));
    last_row_c = (row == (IH - CNT_W'(1)));
`ifdef NMS_DOUBLE_THRESH_EN
    if (keep_c) begin
      if (s1_c >= th_high) begin
        pix_c = STRONG_VAL;
      end else if (s1_c >= th_low) begin
        pix_c = WEAK_VAL;
      end
    end
`else
    if (keep_c) begin
      pix_c = s1_c;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_eol   <= 1'b0;
      dout_eof   <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      dout_valid <= s1_valid;
      dout       <= s1_valid ? pix_c : '0;
      dout_eol   <= s1_valid && last_col_c;
      dout_eof   <= s1_valid && last_col_c && last_row_c;
      if (s1_valid) begin
        if (last_col_c) begin
          col <= '0;
          row <= last_row_c ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/nms_core.md
NMS_CORE -- requirements
Module: nms_core

Interface
REQ-001 SHALL have parameter DATAWID, default 8, pixel magnitude width.
REQ-002 SHALL have parameter WINDOW_DATA_WID, default 72, packed 3x3 window width (9*DATAWID).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din_valid  input  1  window_data and dir valid this cycle.
REQ-006 SHALL have port window_data  input  WINDOW_DATA_WID  3x3 gradient-magnitude window.
REQ-007 SHALL have port dir  input  2  quantized gradient direction of centre pixel, aligned with window_data.
REQ-008 SHALL have port IW  input  11  output frame width in pixels (>=2).
REQ-009 SHALL have port IH  input  11  output frame height in lines (>=2).
REQ-010 SHALL have port dout  output  DATAWID  suppressed/classified pixel.
REQ-011 SHALL have port dout_valid  output  1  dout valid.
REQ-012 SHALL have port dout_eol  output  1  high with last valid pixel of a line.
REQ-013 SHALL have port dout_eof  output  1  high with last valid pixel of a frame.

Function
REQ-014 Byte k of window_data SHALL be bits [8k+7:8k]; byte 4 is centre C; bytes 8,7,6 newest row (newest..oldest column); bytes 5,4,3 middle row; bytes 2,1,0 oldest row.
REQ-015 Neighbour pair SHALL be: dir=0 bytes 5,3; dir=1 bytes 8,0; dir=2 bytes 7,1; dir=3 bytes 6,2.
REQ-016 Stage 1 SHALL register C, selected neighbours N0/N1 and din_valid; stage 2 SHALL compare and register outputs; latency exactly 2 cycles from din_valid to dout_valid.
REQ-017 Pixel SHALL be kept when C>=N0 and C>=N1 (unsigned, ties keep); otherwise dout SHALL be 0.
REQ-018 Without NMS_DOUBLE_THRESH_EN, kept pixel SHALL output dout=C.
REQ-019 Pipeline SHALL not stall; din_valid low cycles SHALL produce dout_valid low exactly 2 cycles later, with dout=0.
REQ-020 Back-to-back din_valid SHALL give one output per cycle, no loss.
REQ-021 Column counter SHALL increment on each dout_valid, wrap to 0 after IW-1; row counter SHALL increment on that wrap, wrap to 0 after IH-1.
REQ-022 dout_eol SHALL assert with dout_valid when column==IW-1; dout_eof SHALL assert when additionally row==IH-1; both 0 otherwise.
REQ-023 IW/IH SHALL be sampled continuously; changing them mid-frame is unsupported (counters compare against current value).

Reset
REQ-024 While rst=1, dout, dout_valid, dout_eol, dout_eof, both pipeline stages and both counters SHALL be 0 on the next edge.
REQ-025 Reset mid-frame SHALL discard in-flight pixels; first valid after reset release SHALL be counted as column 0, row 0.
REQ-026 din_valid asserted in the reset cycle SHALL be ignored.

Configuration
REQ-027 Macro NMS_DOUBLE_THRESH_EN, when defined, SHALL add inputs th_low and th_high (DATAWID each, th_low<=th_high).
REQ-028 With NMS_DOUBLE_THRESH_EN, kept pixel SHALL output 255 if C>=th_high, 128 if th_low<=C<th_high, else 0; suppressed pixel 0; latency unchanged at 2.
REQ-029 Without NMS_DOUBLE_THRESH_EN, th_low/th_high SHALL not exist and REQ-018 applies.

Verification
REQ-030 dir=0, bytes5/4/3 = 10/50/20, din_valid one cycle -> dout=50, dout_valid high exactly 2 cycles later.
REQ-031 dir=2, byte7=60, C=50, byte1=0 -> dout=0; dir=1, byte8=50, C=50, byte0=50 -> dout=50 (tie keeps).
REQ-032 IW=4, IH=2, 8 consecutive valid windows -> dout_eol on outputs 4 and 8, dout_eof only on output 8, counters back to 0.
REQ-033 Alternate din_valid 1/0 for 6 cycles -> dout_valid pattern 1/0 delayed by 2, column count 3.
REQ-034 rst pulsed 1 cycle after 2 of 4 valids in a line (IW=4) -> no outputs from pre-reset inputs; next output is column 0, eol at 4th post-reset output.
REQ-035 NMS_DOUBLE_THRESH_EN, th_low=40, th_high=100, kept C=120/60/30 -> dout=255/128/0.
